// File: rtl/uart_pkg.sv
// Shared UART definitions: parity-mode codes and the TX state encoding.
// The receive side decodes the same parity codes, so they live here.
package uart_pkg;

  localparam logic [2:0] PAR_NONE  = 3'd0;
  localparam logic [2:0] PAR_EVEN  = 3'd1;
  localparam logic [2:0] PAR_ODD   = 3'd2;
  localparam logic [2:0] PAR_MARK  = 3'd3;
  localparam logic [2:0] PAR_SPACE = 3'd4;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t IDLE   = 3'd0;
  localparam tx_state_t START  = 3'd1;
  localparam tx_state_t DATA   = 3'd2;
  localparam tx_state_t PARITY = 3'd3;
  localparam tx_state_t STOP   = 3'd4;

  // Codes 5-7 are reserved and behave like PAR_NONE.
  function automatic logic has_parity(input logic [2:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
           (mode == PAR_MARK) || (mode == PAR_SPACE);
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// Registered parity bit for one TX word, captured when load is high.
// Holds its value between loads so it stays stable for the whole frame.
module uart_parity_gen
  import uart_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        mode,
  input  logic [DATA_W-1:0] data,
  output logic              parity_out
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_out <= 1'b0;
    end else if (load) begin
      case (mode)
        PAR_EVEN: parity_out <= ^data;
        PAR_ODD:  parity_out <= ~^data;
        PAR_MARK: parity_out <= 1'b1;
        default:  parity_out <= 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits, each held CLKS_PER_BIT clocks on a registered tx_out.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [2:0]        parity_mode,
  input  logic              stop2,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  generate
    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2) begin : g_param_check
      $error("uart_tx_framer: DATA_W must be 5..9 and CLKS_PER_BIT >= 2");
    end
  endgenerate

  tx_state_t         state_reg;
  tx_state_t         state_next;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [IDX_W-1:0]  data_idx_reg;
  logic              stop_idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [2:0]        mode_reg;
  logic              stop2_reg;
  logic              tx_out_reg;
  logic              frame_done_reg;
  logic              parity_bit;
  logic              accept;
  logic              bit_end;

  assign tx_ready   = (state_reg == IDLE);
  assign tx_busy    = !tx_ready;
  assign tx_out     = tx_out_reg;
  assign frame_done = frame_done_reg;
  assign accept     = tx_valid && tx_ready;
  assign bit_end    = (bit_cnt_reg == CNT_LAST);

  uart_parity_gen #(
    .DATA_W(DATA_W)
  ) u_parity (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .mode      (parity_mode),
    .data      (tx_data),
    .parity_out(parity_bit)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = START;
      START:  if (bit_end) state_next = DATA;
      DATA: begin
        if (bit_end && data_idx_reg == IDX_LAST)
          state_next = has_parity(mode_reg) ? PARITY : STOP;
      end
      PARITY: if (bit_end) state_next = STOP;
      STOP: begin
        if (bit_end && (!stop2_reg || stop_idx_reg))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      data_idx_reg   <= '0;
      stop_idx_reg   <= 1'b0;
      shift_reg      <= '0;
      mode_reg       <= PAR_NONE;
      stop2_reg      <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= (state_reg == STOP) && (state_next == IDLE);
      if (accept) begin
        bit_cnt_reg  <= '0;
        data_idx_reg <= '0;
        stop_idx_reg <= 1'b0;
        shift_reg    <= tx_data;
        mode_reg     <= parity_mode;
        stop2_reg    <= stop2;
      end else if (state_reg != IDLE) begin
        bit_cnt_reg <= bit_end ? '0 : bit_cnt_reg + CNT_W'(1);
        if (bit_end && state_reg == DATA) begin
          shift_reg    <= shift_reg >> 1;
          data_idx_reg <= data_idx_reg + IDX_W'(1);
        end
        if (bit_end && state_reg == STOP)
          stop_idx_reg <= 1'b1;
      end
    end
  end

  // The line lags the state by one clock, so every bit is shifted uniformly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_out_reg <= 1'b1;
    end else begin
      case (state_reg)
        START:   tx_out_reg <= 1'b0;
        DATA:    tx_out_reg <= shift_reg[0];
        PARITY:  tx_out_reg <= parity_bit;
        default: tx_out_reg <= 1'b1;
      endcase
    end
  end

endmodule
